dunit_mem_dump: RTL and testbench

- Debug-unit sequencer that reads data memory through its debug read port and streams the contents, one byte at a time, to the UART transmitter.
- Sits downstream of the data memory's debug port. It drives the debug address and consumes the 32-bit word that the memory returns asynchronously.
- Sits upstream of the UART TX, which it drives with a start/done handshake.
- The host commands a dump of N words. Words are read from address 0, and the bytes of each word are sent MSB first, matching the memory's big-endian byte order.

---
 rtl/dunit_mem_dump_if.sv | 23 ++
 rtl/dunit_mem_dump.sv | 120 ++++++++++++
 tb/tb_dunit_mem_dump.sv | 307 ++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/dunit_mem_dump_if.sv
// Debug-unit dump bus: memory debug read port plus UART TX start/done handshake.
interface dunit_mem_dump_if #(
  parameter int unsigned NB_WIDTH = 32,
  parameter int unsigned NB_ADDR  = 9,
  parameter int unsigned NB_BYTE  = 8
);
  logic [NB_ADDR-1:0]  dunit_addr;
  logic [NB_WIDTH-1:0] dunit_data;
  logic                tx_start;
  logic [NB_BYTE-1:0]  tx_data;
  logic                tx_done;

  // The dump sequencer drives address and TX byte; memory and UART answer.
  modport master (
    output dunit_addr, tx_start, tx_data,
    input  dunit_data, tx_done
  );

  modport slave (
    input  dunit_addr, tx_start, tx_data,
    output dunit_data, tx_done
  );
endinterface

// File: rtl/dunit_mem_dump.sv
// Streams N words of data memory, MSB byte first, from address 0 to the UART TX.
module dunit_mem_dump #(
  parameter int unsigned NB_WIDTH = 32,
  parameter int unsigned NB_ADDR  = 9,
  parameter int unsigned NB_BYTE  = 8
) (
  input  logic               i_clk,
  input  logic               i_reset,
  input  logic               i_start,
  input  logic [NB_ADDR-2:0] i_num_words,
  output logic               o_busy,
  output logic               o_done,
  dunit_mem_dump_if.master   bus
);

  localparam int unsigned NumBytes = NB_WIDTH / NB_BYTE;
  localparam int unsigned IdxW     = (NumBytes > 1) ? $clog2(NumBytes) : 1;
  localparam logic [IdxW-1:0]    LastIdx  = IdxW'(NumBytes - 1);
  localparam logic [NB_ADDR-1:0] AddrStep = NB_ADDR'(NumBytes);
  localparam logic [NB_ADDR-2:0] CntOne   = (NB_ADDR-1)'(1);

  typedef enum logic [2:0] {
    StIdle,
    StLoad,
    StSend,
    StWait,
    StNext,
    StDone
  } state_e;

  state_e              state_q;
  logic [NB_ADDR-1:0]  addr_q;
  logic [NB_ADDR-2:0]  cnt_q;
  logic [NB_WIDTH-1:0] word_q;
  logic [IdxW-1:0]     idx_q;
  logic                tx_start_q;
  logic [NB_BYTE-1:0]  tx_data_q;
  logic                busy_q;
  logic                done_q;
  logic                tx_done_q;

  logic                done_evt;
  logic [NB_WIDTH-1:0] word_shifted;

  // Byte selection (index 0 = most significant) and tx_done rising-edge detect, so a
  // held-high done advances only one byte.
  always_comb begin
    word_shifted = word_q << (32'(idx_q) * NB_BYTE);
    done_evt     = bus.tx_done & ~tx_done_q;
  end

  // Sequencer FSM; every output is a register written here.
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      state_q    <= StIdle;
      addr_q     <= '0;
      cnt_q      <= '0;
      word_q     <= '0;
      idx_q      <= '0;
      tx_start_q <= 1'b0;
      tx_data_q  <= '0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      tx_done_q  <= 1'b0;
    end else begin
      tx_done_q  <= bus.tx_done;
      tx_start_q <= 1'b0;
      done_q     <= 1'b0;
      case (state_q)
        StIdle: begin
          if (i_start) begin
            cnt_q   <= i_num_words;
            addr_q  <= '0;
            busy_q  <= 1'b1;
            state_q <= (i_num_words == '0) ? StDone : StLoad;
          end
        end
        StLoad: begin
          // Memory read is asynchronous; the word present now is the one dumped.
          word_q  <= bus.dunit_data;
          idx_q   <= '0;
          state_q <= StSend;
        end
        StSend: begin
          tx_data_q  <= word_shifted[NB_WIDTH-1 -: NB_BYTE];
          tx_start_q <= 1'b1;
          state_q    <= StWait;
        end
        StWait: begin
          if (done_evt) begin
            if (idx_q == LastIdx) begin
              state_q <= StNext;
            end else begin
              idx_q   <= idx_q + IdxW'(1);
              state_q <= StSend;
            end
          end
        end
        StNext: begin
          cnt_q   <= cnt_q - CntOne;
          addr_q  <= addr_q + AddrStep;
          state_q <= (cnt_q == CntOne) ? StDone : StLoad;
        end
        StDone: begin
          done_q  <= 1'b1;
          busy_q  <= 1'b0;
          state_q <= StIdle;
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  assign bus.dunit_addr = addr_q;
  assign bus.tx_start   = tx_start_q;
  assign bus.tx_data    = tx_data_q;
  assign o_busy         = busy_q;
  assign o_done         = done_q;

endmodule

// File: tb/tb_dunit_mem_dump.sv
// Self-checking bench for dunit_mem_dump: a 9-bit-address instance for the main
// scenarios and a 4-bit-address instance for address wrap.
module tb_dunit_mem_dump;

  logic       clk;
  logic       rst;
  logic       start9;
  logic [7:0] num9;
  logic       start4;
  logic [2:0] num4;
  logic       tx_done;
  logic       busy9, done9, busy4, done4;

  int checks;
  int failures;

  logic [7:0] mem9 [512];
  logic [7:0] mem4 [16];

  dunit_mem_dump_if #(.NB_WIDTH(32), .NB_ADDR(9), .NB_BYTE(8)) b9 ();
  dunit_mem_dump_if #(.NB_WIDTH(32), .NB_ADDR(4), .NB_BYTE(8)) b4 ();

  dunit_mem_dump #(.NB_WIDTH(32), .NB_ADDR(9), .NB_BYTE(8)) dut9 (
    .i_clk       (clk),
    .i_reset     (rst),
    .i_start     (start9),
    .i_num_words (num9),
    .o_busy      (busy9),
    .o_done      (done9),
    .bus         (b9)
  );

  dunit_mem_dump #(.NB_WIDTH(32), .NB_ADDR(4), .NB_BYTE(8)) dut4 (
    .i_clk       (clk),
    .i_reset     (rst),
    .i_start     (start4),
    .i_num_words (num4),
    .o_busy      (busy4),
    .o_done      (done4),
    .bus         (b4)
  );

  // Big-endian asynchronous memories.
  assign b9.dunit_data = {mem9[{b9.dunit_addr[8:2], 2'd0}], mem9[{b9.dunit_addr[8:2], 2'd1}],
                          mem9[{b9.dunit_addr[8:2], 2'd2}], mem9[{b9.dunit_addr[8:2], 2'd3}]};
  assign b4.dunit_data = {mem4[{b4.dunit_addr[3:2], 2'd0}], mem4[{b4.dunit_addr[3:2], 2'd1}],
                          mem4[{b4.dunit_addr[3:2], 2'd2}], mem4[{b4.dunit_addr[3:2], 2'd3}]};
  assign b9.tx_done = tx_done;
  assign b4.tx_done = tx_done;

  // Observation mux: sel picks the instance under test.
  logic       sel;
  logic       obs_start, obs_busy, obs_done;
  logic [7:0] obs_data;
  logic [8:0] obs_addr;
  assign obs_start = sel ? b4.tx_start : b9.tx_start;
  assign obs_data  = sel ? b4.tx_data : b9.tx_data;
  assign obs_addr  = sel ? {5'd0, b4.dunit_addr} : b9.dunit_addr;
  assign obs_busy  = sel ? busy4 : busy9;
  assign obs_done  = sel ? done4 : done9;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Runs one dump and checks bytes, word addresses, handshake timing and completion
  // against a list built from memory contents before the start.
  task automatic run_dump(input bit s, input int n, input int dly, input int hold,
                          input bit load_poke, input int restart_at, input string name);
    logic [7:0] exp_b[$];
    logic [8:0] exp_a[$];
    int asz, e_cnt, c, nb, cd, hc, last_de, done_cnt, done_c, budget, exp_c;
    bit finished;
    asz = s ? 16 : 512;
    for (int w = 0; w < n; w++) begin
      int a;
      a = (4 * w) % asz;
      exp_a.push_back(9'(a));
      for (int j = 0; j < 4; j++) exp_b.push_back(s ? mem4[a + j] : mem9[a + j]);
    end
    e_cnt = 4 * n;
    sel = s;
    @(negedge clk);
    if (s) begin start4 = 1'b1; num4 = 3'(n); end
    else begin start9 = 1'b1; num9 = 8'(n); end
    @(posedge clk);
    #1;
    start4 = 1'b0;
    start9 = 1'b0;
    c = 0;
    checks++;
    if (obs_busy !== 1'b1) begin
      failures++;
      $display("FAIL %s busy_after_start: got %b expected 1", name, obs_busy);
    end
    nb = 0; cd = 0; hc = 0; last_de = -100; done_cnt = 0; done_c = -1; finished = 0;
    budget = 60 * (n + 1) + 40;
    while (!finished && c < budget) begin
      @(posedge clk);
      #1;
      c++;
      tx_done = 1'b0;
      start9  = 1'b0;
      start4  = 1'b0;
      if (cd > 0) begin
        cd--;
        if (cd == 0) begin hc = hold; last_de = c + 1; end
      end
      if (hc > 0) begin tx_done = 1'b1; hc--; end
      if (load_poke && nb > 0 && nb % 4 == 0 && nb < e_cnt && c == last_de + 1) tx_done = 1'b1;
      if (c == restart_at) begin
        if (s) begin start4 = 1'b1; num4 = 3'd1; end
        else begin start9 = 1'b1; num9 = 8'd1; end
      end
      if (obs_start) begin
        checks++;
        if (nb >= e_cnt) begin
          failures++;
          $display("FAIL %s extra_byte: got byte #%0d expected %0d bytes", name, nb, e_cnt);
        end else begin
          if (obs_data !== exp_b[nb]) begin
            failures++;
            $display("FAIL %s byte[%0d]: got %h expected %h", name, nb, obs_data, exp_b[nb]);
          end
          checks++;
          if (obs_addr !== exp_a[nb / 4]) begin
            failures++;
            $display("FAIL %s addr[%0d]: got %0d expected %0d", name, nb, obs_addr,
                     exp_a[nb / 4]);
          end
          exp_c = (nb == 0) ? 2 : ((nb % 4 == 0) ? last_de + 3 : last_de + 1);
          checks++;
          if (c != exp_c) begin
            failures++;
            $display("FAIL %s start_timing[%0d]: got cycle %0d expected %0d", name, nb, c, exp_c);
          end
          checks++;
          if (obs_busy !== 1'b1) begin
            failures++;
            $display("FAIL %s busy_during[%0d]: got %b expected 1", name, nb, obs_busy);
          end
        end
        nb++;
        cd = dly;
      end
      if (obs_done) begin
        done_cnt++;
        if (done_c < 0) done_c = c;
      end
      if (done_c >= 0 && c >= done_c + 4) finished = 1;
    end
    tx_done = 1'b0;
    checks++;
    if (done_c < 0) begin
      failures++;
      $display("FAIL %s done_timeout: got no o_done in %0d cycles expected one", name, budget);
    end else begin
      exp_c = (n == 0) ? 1 : last_de + 2;
      if (done_c != exp_c) begin
        failures++;
        $display("FAIL %s done_timing: got cycle %0d expected %0d", name, done_c, exp_c);
      end
    end
    checks++;
    if (done_cnt != 1) begin
      failures++;
      $display("FAIL %s done_count: got %0d expected 1", name, done_cnt);
    end
    checks++;
    if (nb != e_cnt) begin
      failures++;
      $display("FAIL %s byte_count: got %0d expected %0d", name, nb, e_cnt);
    end
    checks++;
    if (obs_busy !== 1'b0) begin
      failures++;
      $display("FAIL %s busy_after_done: got %b expected 0", name, obs_busy);
    end
  endtask

  task automatic test_reset;
    rst = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    checks++;
    if ({b9.dunit_addr, b9.tx_start, b9.tx_data, busy9, done9,
         b4.dunit_addr, b4.tx_start, b4.tx_data, busy4, done4} !== '0) begin
      failures++;
      $display("FAIL reset_state: got %h/%b/%h/%b/%b expected all zero",
               b9.dunit_addr, b9.tx_start, b9.tx_data, busy9, done9);
    end
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic test_reset_mid_dump;
    bit seen, bad;
    sel = 1'b0;
    for (int i = 0; i < 12; i++) mem9[i] = 8'hD0 + 8'(i);
    @(negedge clk);
    start9 = 1'b1;
    num9   = 8'd3;
    @(posedge clk);
    #1;
    start9 = 1'b0;
    seen = 0;
    for (int i = 0; i < 10 && !seen; i++) begin
      @(posedge clk);
      #1;
      if (obs_start) seen = 1;
    end
    checks++;
    if (!seen) begin
      failures++;
      $display("FAIL mid_reset first_start: got none expected o_tx_start");
    end
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    #1;
    checks++;
    if ({b9.dunit_addr, b9.tx_start, b9.tx_data, busy9, done9} !== '0) begin
      failures++;
      $display("FAIL mid_reset outputs: got addr=%0d start=%b data=%h busy=%b done=%b expected 0",
               b9.dunit_addr, b9.tx_start, b9.tx_data, busy9, done9);
    end
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    tx_done = 1'b1;
    @(negedge clk);
    tx_done = 1'b0;
    bad = 0;
    repeat (12) begin
      @(posedge clk);
      #1;
      if (obs_start || obs_done || obs_busy) bad = 1;
    end
    checks++;
    if (bad) begin
      failures++;
      $display("FAIL mid_reset after_release: got activity expected idle");
    end
  endtask

  task automatic test_single_word;
    mem9[0] = 8'hDE; mem9[1] = 8'hAD; mem9[2] = 8'hBE; mem9[3] = 8'hEF;
    run_dump(1'b0, 1, 5, 1, 1'b0, -1, "single_word");
  endtask

  task automatic test_three_words;
    logic [31:0] words [3];
    words[0] = 32'h11223344; words[1] = 32'h55667788; words[2] = 32'h99AABBCC;
    for (int w = 0; w < 3; w++)
      for (int j = 0; j < 4; j++) mem9[4 * w + j] = words[w][31 - 8 * j -: 8];
    run_dump(1'b0, 3, 5, 1, 1'b0, -1, "three_words");
  endtask

  task automatic test_zero_count;
    run_dump(1'b0, 0, 5, 1, 1'b0, -1, "zero_count");
  endtask

  task automatic test_handshake;
    for (int i = 0; i < 16; i++) mem9[i] = 8'($urandom);
    run_dump(1'b0, 2, 4, 1, 1'b0, 8, "restart_while_busy");
    run_dump(1'b0, 2, 4, 3, 1'b0, -1, "done_held");
    run_dump(1'b0, 3, 3, 1, 1'b1, -1, "done_in_load");
  endtask

  task automatic test_random;
    repeat (4) begin
      for (int i = 0; i < 512; i++) mem9[i] = 8'($urandom);
      run_dump(1'b0, int'($urandom_range(1, 4)), int'($urandom_range(2, 6)), 1, 1'b0, -1,
               "random");
    end
  endtask

  task automatic test_wrap;
    for (int i = 0; i < 16; i++) mem4[i] = 8'($urandom);
    run_dump(1'b1, 5, 3, 1, 1'b0, -1, "wrap");
  endtask

  initial begin
    checks = 0;
    failures = 0;
    rst = 1'b1;
    start9 = 1'b0;
    num9 = '0;
    start4 = 1'b0;
    num4 = '0;
    tx_done = 1'b0;
    sel = 1'b0;
    for (int i = 0; i < 512; i++) mem9[i] = '0;
    for (int i = 0; i < 16; i++) mem4[i] = '0;
    test_reset();
    test_reset_mid_dump();
    test_single_word();
    test_three_words();
    test_zero_count();
    test_handshake();
    test_random();
    test_wrap();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
